// File: rtl/sequenciador_excecao.sv
// sequenciador_excecao: exception sequencer that saves EPC, fetches the handler
// byte at 253/254/255 and loads it into PC, passing memory controls through while idle.
module sequenciador_excecao (
   input  logic        clk,
   input  logic        reset,
   input  logic        excOpcodeInvalido,
   input  logic        excOverflow,
   input  logic        excDivZero,
   input  logic [31:0] valorPC,
   input  logic [31:0] memDataOut,
   input  logic [3:0]  muxAddrControle,
   input  logic        memWriteControle,
   output logic [3:0]  MuxAddr,
   output logic        memWrite,
   output logic        epcWrite,
   output logic [31:0] valorEPC,
   output logic        pcWrite,
   output logic [31:0] novoPC,
   output logic [1:0]  causa,
   output logic        ocupado,
   output logic        excPerdida
);
   typedef enum logic [2:0] {IDLE, SALVA, ENDERECA, ESPERA, CARREGA} estado_t;
   estado_t     estado;
   logic [31:0] epc_q, novo_q;
   logic [3:0]  mux_q;
   logic        algum;
   logic [1:0]  prox_causa;
   assign algum      = excOpcodeInvalido | excOverflow | excDivZero;
   assign prox_causa = excOpcodeInvalido ? 2'b01 : excOverflow ? 2'b10 : 2'b11;
   assign MuxAddr    = ocupado ? mux_q : muxAddrControle;
   assign memWrite   = memWriteControle & ~ocupado;
   assign valorEPC   = epcWrite ? valorPC - 32'd4 : epc_q;
   assign novoPC     = pcWrite ? {24'b0, memDataOut[7:0]} : novo_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado     <= IDLE;
         causa      <= 2'b00;
         excPerdida <= 1'b0;
         epc_q      <= '0;
         novo_q     <= '0;
         mux_q      <= '0;
         epcWrite   <= 1'b0;
         pcWrite    <= 1'b0;
         ocupado    <= 1'b0;
      end else begin
         epcWrite <= 1'b0;
         pcWrite  <= 1'b0;
         if (ocupado && algum) excPerdida <= 1'b1;
         case (estado)
            IDLE: if (algum) begin
               estado   <= SALVA;
               causa    <= prox_causa;
               epcWrite <= 1'b1;
               ocupado  <= 1'b1;
               mux_q    <= 4'b0000;
            end
            SALVA: begin
               estado <= ENDERECA;
               epc_q  <= valorPC - 32'd4;
               mux_q  <= {2'b00, causa} + 4'd2;
            end
            ENDERECA: estado <= ESPERA;
            ESPERA: begin
               estado  <= CARREGA;
               pcWrite <= 1'b1;
            end
            default: begin
               estado  <= IDLE;
               ocupado <= 1'b0;
               novo_q  <= {24'b0, memDataOut[7:0]};
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sequenciador_excecao.sv
// tb_sequenciador_excecao: directed vectors with hand-computed expectations.
module tb_sequenciador_excecao;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        excOpcodeInvalido = 1'b0, excOverflow = 1'b0, excDivZero = 1'b0;
   logic [31:0] valorPC = '0, memDataOut = '0;
   logic [3:0]  muxAddrControle = '0;
   logic        memWriteControle = 1'b0;
   logic [3:0]  MuxAddr;
   logic        memWrite, epcWrite, pcWrite, ocupado, excPerdida;
   logic [31:0] valorEPC, novoPC;
   logic [1:0]  causa;
   int checks = 0, failures = 0;

   sequenciador_excecao dut (
      .clk(clk), .reset(reset),
      .excOpcodeInvalido(excOpcodeInvalido), .excOverflow(excOverflow), .excDivZero(excDivZero),
      .valorPC(valorPC), .memDataOut(memDataOut),
      .muxAddrControle(muxAddrControle), .memWriteControle(memWriteControle),
      .MuxAddr(MuxAddr), .memWrite(memWrite), .epcWrite(epcWrite), .valorEPC(valorEPC),
      .pcWrite(pcWrite), .novoPC(novoPC), .causa(causa), .ocupado(ocupado), .excPerdida(excPerdida)
   );

   always #5 clk = ~clk;

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: obtido=%h esperado=%h", tag, obs, exp);
      end
   endtask

   task automatic passo;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      reset = 1'b1;
      muxAddrControle  = 4'b0010;
      memWriteControle = 1'b1;
      passo();
      verifica("idle_mux", MuxAddr, 4'b0010);
      verifica("idle_memwrite", memWrite, 1);
      verifica("idle_ocupado", ocupado, 0);
      verifica("idle_epcwrite", epcWrite, 0);
      verifica("idle_pcwrite", pcWrite, 0);
      verifica("idle_causa", causa, 0);
      verifica("idle_perdida", excPerdida, 0);
      verifica("idle_epc", valorEPC, 0);
      verifica("idle_novopc", novoPC, 0);
      // overflow sequence
      valorPC = 32'h104;
      excOverflow = 1'b1;
      passo();
      excOverflow = 1'b0;
      verifica("ovf_salva_epcwrite", epcWrite, 1);
      verifica("ovf_salva_epc", valorEPC, 32'h100);
      verifica("ovf_salva_mux", MuxAddr, 4'b0000);
      verifica("ovf_salva_ocupado", ocupado, 1);
      verifica("ovf_salva_memwrite", memWrite, 0);
      verifica("ovf_causa", causa, 2'b10);
      passo();
      verifica("ovf_end_mux", MuxAddr, 4'b0100);
      verifica("ovf_end_epcwrite", epcWrite, 0);
      passo();
      verifica("ovf_esp_mux", MuxAddr, 4'b0100);
      verifica("ovf_esp_pcwrite", pcWrite, 0);
      memDataOut = 32'hABCD_EF5C;
      passo();
      verifica("ovf_car_pcwrite", pcWrite, 1);
      verifica("ovf_car_novopc", novoPC, 32'h5C);
      verifica("ovf_car_mux", MuxAddr, 4'b0100);
      verifica("ovf_car_ocupado", ocupado, 1);
      passo();
      verifica("ovf_ret_ocupado", ocupado, 0);
      verifica("ovf_ret_pcwrite", pcWrite, 0);
      verifica("ovf_ret_mux", MuxAddr, 4'b0010);
      verifica("ovf_ret_memwrite", memWrite, 1);
      verifica("ovf_ret_novopc", novoPC, 32'h5C);
      verifica("ovf_ret_epc", valorEPC, 32'h100);
      verifica("ovf_ret_causa", causa, 2'b10);
      // simultaneous opcode + div-zero, then div-zero lost during ESPERA
      excOpcodeInvalido = 1'b1;
      excDivZero = 1'b1;
      passo();
      excOpcodeInvalido = 1'b0;
      excDivZero = 1'b0;
      verifica("sim_causa", causa, 2'b01);
      passo();
      verifica("sim_mux", MuxAddr, 4'b0011);
      verifica("sim_perdida", excPerdida, 0);
      passo();
      excDivZero = 1'b1;
      passo();
      excDivZero = 1'b0;
      verifica("lost_perdida", excPerdida, 1);
      verifica("lost_memwrite", memWrite, 0);
      verifica("lost_pcwrite", pcWrite, 1);
      verifica("lost_mux", MuxAddr, 4'b0011);
      verifica("lost_causa", causa, 2'b01);
      passo();
      verifica("lost_ret_ocupado", ocupado, 0);
      verifica("lost_ret_causa", causa, 2'b01);
      // valorPC = 0 wrap, then back-to-back event at the CARREGA edge
      valorPC = 32'h0;
      excDivZero = 1'b1;
      passo();
      excDivZero = 1'b0;
      verifica("dz_epc", valorEPC, 32'hFFFF_FFFC);
      verifica("dz_causa", causa, 2'b11);
      passo();
      verifica("dz_mux", MuxAddr, 4'b0101);
      passo();
      passo();
      verifica("dz_car_pcwrite", pcWrite, 1);
      excOverflow = 1'b1;
      passo();
      verifica("b2b_ignorado", ocupado, 0);
      verifica("b2b_causa", causa, 2'b11);
      passo();
      excOverflow = 1'b0;
      verifica("b2b_novo_ocupado", ocupado, 1);
      verifica("b2b_novo_causa", causa, 2'b10);
      // asynchronous reset during ENDERECA
      passo();
      verifica("rst_pre_mux", MuxAddr, 4'b0100);
      reset = 1'b0;
      #1;
      verifica("rst_ocupado", ocupado, 0);
      verifica("rst_mux", MuxAddr, 4'b0010);
      verifica("rst_perdida", excPerdida, 0);
      verifica("rst_causa", causa, 0);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         passo();
         verifica("rst_pcwrite", pcWrite, 0);
         verifica("rst_idle", ocupado, 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sequenciador_excecao.md
# sequenciador_excecao

Exception sequencer for the multicycle datapath. On an invalid-opcode, overflow or divide-by-zero event it takes over the memory-address multiplexer, saves EPC, reads the handler byte at 253/254/255, and loads PC with it. While idle it passes the main control unit's memory controls through unchanged.

## Interface
- No parameters; all widths are fixed.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 forces IDLE immediately.
- excOpcodeInvalido  in  1  invalid-opcode event, sampled each clk while IDLE.
- excOverflow  in  1  ALU overflow event.
- excDivZero  in  1  divide-by-zero event.
- valorPC  in  32  current PC; already incremented past the faulting instruction.
- memDataOut  in  32  memory read data; only [7:0] is used.
- muxAddrControle  in  4  memory-mux select from the main control unit.
- memWriteControle  in  1  memory write enable from the main control unit.
- MuxAddr  out  4  select driving the memory-address mux.
- memWrite  out  1  memory write enable to memory.
- epcWrite  out  1  EPC register load strobe.
- valorEPC  out  32  EPC write data.
- pcWrite  out  1  PC load strobe (exception path).
- novoPC  out  32  PC write data.
- causa  out  2  latched cause: 01 opcode, 10 overflow, 11 div-zero, 00 none.
- ocupado  out  1  high while sequencing; main control must stall.
- excPerdida  out  1  sticky flag: an exception arrived while busy.

## Operation
- States: IDLE, SALVA, ENDERECA, ESPERA, CARREGA.
- IDLE:
  - MuxAddr = muxAddrControle and memWrite = memWriteControle, both combinational.
  - All strobes are 0 and ocupado = 0.
- IDLE → SALVA: taken when any exc input is 1 at a clk edge.
  - causa latches the highest-priority active input.
  - Priority: opcode > overflow > div-zero.
  - Lower-priority simultaneous events are discarded and do not set excPerdida.
- SALVA (1 cycle):
  - epcWrite = 1.
  - valorEPC = valorPC − 4, modulo 2^32; valorPC = 0 gives 0xFFFFFFFC.
- ENDERECA (1 cycle): MuxAddr selects the vector address.
  - causa 01 → 4'b0011 (253).
  - causa 10 → 4'b0100 (254).
  - causa 11 → 4'b0101 (255).
- ESPERA (1 cycle): MuxAddr is held at the same value, covering the 1-cycle memory read latency.
- CARREGA (1 cycle):
  - pcWrite = 1.
  - novoPC = {24'b0, memDataOut[7:0]}, zero-extended.
  - MuxAddr is still held.
  - Next state is IDLE.
- In SALVA through CARREGA:
  - ocupado = 1 and memWrite = 0, regardless of memWriteControle.
  - MuxAddr in SALVA = 4'b0000.
- Exc inputs are ignored while ocupado = 1; any one asserted sets excPerdida = 1.
- excPerdida clears only on reset.
- causa holds its value after return to IDLE until the next exception overwrites it.
- Outside their active state, valorEPC and novoPC hold their last values; they are don't-care while their strobe is 0.

## Timing
- Reset values:
  - State IDLE; causa = 00; excPerdida = 0.
  - valorEPC = 0; novoPC = 0.
  - epcWrite = 0; pcWrite = 0; ocupado = 0.
  - memWrite and MuxAddr pass through from the control unit.
- Exception sampled at edge N:
  - SALVA in cycle N+1.
  - ENDERECA in N+2.
  - ESPERA in N+3.
  - CARREGA in N+4.
  - IDLE in N+5.
- Fixed latency of 5 cycles from the sampling edge to the PC being loaded.
- Back-to-back exceptions: an event present at the edge that enters IDLE (end of CARREGA) is ignored and sets excPerdida. An event first sampled in IDLE at N+5 starts a new sequence.
- Reset asserted mid-sequence: the block returns to IDLE asynchronously and releases ocupado. A pending pcWrite or epcWrite is dropped.
- All strobes are registered-state decodes: glitch-free, high for exactly one cycle.

## Test plan
- Reset, then muxAddrControle = 4'b0010 and memWriteControle = 1 in IDLE → MuxAddr = 0010, memWrite = 1, ocupado = 0, all strobes 0.
- excOverflow pulse with valorPC = 0x00000104 and memDataOut[7:0] = 0x5C in CARREGA:
  - epcWrite with valorEPC = 0x00000100 at N+1.
  - MuxAddr = 0100 at N+2 and N+3.
  - pcWrite with novoPC = 0x0000005C at N+4.
  - causa = 10.
- excOpcodeInvalido and excDivZero asserted together → causa = 01, MuxAddr = 0011, excPerdida stays 0.
- excDivZero pulsed during ESPERA with memWriteControle = 1 → excPerdida = 1, memWrite = 0, sequence completes unchanged.
- reset asserted during ENDERECA → next observation is IDLE, ocupado = 0, pcWrite never asserts.
- valorPC = 0 with excDivZero → valorEPC = 0xFFFFFFFC, MuxAddr = 0101.
